processor_pio_irq: RTL

//  Parametrised Avalon-MM GPIO for the Nios processor system, generalising the output-only PIO.

---
 rtl/processor_pio_pkg.sv | 20 ++
 rtl/pio_sync_edge.sv | 46 ++++
 rtl/processor_pio_irq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/processor_pio_pkg.sv
// rtl/processor_pio_pkg.sv - shared constants and types for the processor PIO with interrupt
package processor_pio_pkg;

    localparam logic [2:0] ADDR_DATA        = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET      = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } prime_state_t;

endpackage

// File: rtl/pio_sync_edge.sv
// rtl/pio_sync_edge.sv - pin synchroniser chain, previous-sample register and edge vector
module pio_sync_edge
    import processor_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign in_sync = chain[SYNC_STAGES-1];

    generate
        if (EDGE_MODE == EDGE_FALL) begin : g_fall
            assign edge_det = ~in_sync & prev;
        end else if (EDGE_MODE == EDGE_ANY) begin : g_any
            assign edge_det = in_sync ^ prev;
        end else begin : g_rise
            assign edge_det = in_sync & ~prev;
        end
    endgenerate

endmodule

// File: rtl/processor_pio_irq.sv
// rtl/processor_pio_irq.sv - Avalon-MM GPIO with direction, edge capture, masked irq and set/clear
module processor_pio_irq
    import processor_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_MODE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] ecap;
    logic [WIDTH-1:0] ecap_clr;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] rd;

    prime_state_t state, state_next;
    logic [2:0]   prime_cnt, prime_cnt_next;
    logic         run;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .in_sync  (in_sync),
        .edge_det (edge_det)
    );

    // Hold off capture until the synchroniser and prev have been refilled from the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
        end else begin
            state     <= state_next;
            prime_cnt <= prime_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        prime_cnt_next = prime_cnt;
        case (state)
            ST_PRIME: begin
                prime_cnt_next = prime_cnt + 3'd1;
                if (prime_cnt == 3'(SYNC_STAGES)) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign run = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
            oe       <= '0;
            irqmask  <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:      data_out <= wd;
                ADDR_DIRECTION: oe       <= wd;
                ADDR_IRQMASK:   irqmask  <= wd;
                ADDR_OUTSET:    data_out <= data_out | wd;
                ADDR_OUTCLEAR:  data_out <= data_out & ~wd;
                default: ;
            endcase
        end
    end

    // A fresh edge in the same cycle as a clearing write keeps the bit set.
    assign ecap_clr = (wr && address == ADDR_EDGECAPTURE) ? wd : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ecap <= '0;
        end else begin
            ecap <= (ecap & ~ecap_clr) | (run ? edge_det : '0);
        end
    end

    assign irq      = |(ecap & irqmask);
    assign out_port = data_out;

    always_comb begin
        rd = '0;
        case (address)
            ADDR_DATA:        rd = (oe & data_out) | (~oe & in_sync);
            ADDR_DIRECTION:   rd = oe;
            ADDR_IRQMASK:     rd = irqmask;
            ADDR_EDGECAPTURE: rd = ecap;
            default:          rd = '0;
        endcase
    end

    always_comb begin
        readdata            = '0;
        readdata[WIDTH-1:0] = rd;
    end

endmodule
